match_filter_tx: RTL and testbench

MATCH_FILTER_TX -- requirements
Module: match_filter_tx

---
 rtl/match_filter_tx.sv | 162 ++++++++++++++++
 tb/tb_match_filter_tx.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/match_filter_tx.sv
// Chip-sequence transmitter: replays a stored I/Q chip pattern as +/-A samples.
// Optional MFTX_REPEAT_EN: word 1 [11:8] selects R extra back-to-back passes.
module match_filter_tx #(
  parameter int SAMPLE_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       txstrobe,
  input  logic                       start,
  input  logic [31:0]                cdata,
  input  logic [3:0]                 cstate,
  input  logic                       cwrite,
  output logic signed [SAMPLE_W-1:0] tx_i,
  output logic signed [SAMPLE_W-1:0] tx_q,
  output logic                       tx_valid,
  output logic                       busy,
  output logic                       done,
  output logic [15:0]                debugbus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    SEND   = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [31:0] mem [16];
  logic [14:0] amp;
  logic [7:0]  n_chips;
  logic [7:0]  idx;
  logic [3:0]  rep_cnt;
  logic [3:0]  rep_ld;
  logic [31:0] cur_i;
  logic [31:0] cur_q;
  logic        pend;

  logic [7:0]  n_raw;
  logic [7:0]  n_ld;
  logic [3:0]  wi;
  logic [1:0]  st;
  logic        accept;
  logic        fire;
  logic        more;

  logic signed [SAMPLE_W-1:0] pos;
  logic signed [SAMPLE_W-1:0] neg;

  assign n_raw = mem[1][7:0];
  assign n_ld  = (n_raw > 8'd224) ? 8'd224 : n_raw;
  assign wi    = {idx[7:5], 1'b0} + 4'd2;
  assign pos   = SAMPLE_W'({1'b0, amp});
  assign neg   = -pos;
  assign more  = (rep_cnt != 4'd0);
  assign st    = state;

`ifdef MFTX_REPEAT_EN
  assign rep_ld = mem[1][11:8];
`else
  assign rep_ld = 4'd0;
`endif

  // Store has no reset so configuration survives an aborted sequence
  always_ff @(posedge clk) begin
    if (state == IDLE && cwrite) begin
      mem[cstate] <= cdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    fire     = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start && !cwrite) begin
          accept   = 1'b1;
          state_nx = FETCH;
        end
      end
      FETCH: begin
        state_nx = (n_chips == 8'd0) ? FINISH : SEND;
      end
      SEND: begin
        if (txstrobe || pend) begin
          fire = 1'b1;
          if (idx == 8'd0) begin
            state_nx = more ? FETCH : FINISH;
          end else if (idx[4:0] == 5'd0) begin
            state_nx = FETCH;
          end
        end
      end
      FINISH: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      amp      <= '0;
      n_chips  <= '0;
      idx      <= '0;
      rep_cnt  <= '0;
      cur_i    <= '0;
      cur_q    <= '0;
      pend     <= 1'b0;
      tx_i     <= '0;
      tx_q     <= '0;
      tx_valid <= 1'b0;
    end else begin
      tx_valid <= fire;
      // A strobe landing during FETCH is held for the first SEND cycle
      pend     <= (state == FETCH) && (pend || txstrobe);
      if (accept) begin
        amp     <= mem[0][14:0];
        n_chips <= n_ld;
        idx     <= (n_ld == 8'd0) ? 8'd0 : n_ld - 8'd1;
        rep_cnt <= rep_ld;
      end
      if (state == FETCH) begin
        cur_i <= mem[wi];
        cur_q <= mem[{wi[3:1], 1'b1}];
      end
      if (fire) begin
        tx_i <= cur_i[idx[4:0]] ? pos : neg;
        tx_q <= cur_q[idx[4:0]] ? pos : neg;
        if (idx == 8'd0) begin
          if (more) begin
            rep_cnt <= rep_cnt - 4'd1;
            idx     <= n_chips - 8'd1;
          end
        end else begin
          idx <= idx - 8'd1;
        end
      end
      if (state == FINISH) begin
        tx_i <= '0;
        tx_q <= '0;
      end
    end
  end

  assign debugbus = {busy, done, tx_valid, st, idx, 3'b000};

endmodule

// File: tb/tb_match_filter_tx.sv
// Directed bench for match_filter_tx with a chip-sequence reference model.
// Define MFTX_REPEAT_EN for both files to cover the repeat build.
module tb_match_filter_tx;
  localparam int SW = 16;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 txstrobe = 1'b0;
  logic                 start = 1'b0;
  logic [31:0]          cdata = '0;
  logic [3:0]           cstate = '0;
  logic                 cwrite = 1'b0;
  logic signed [SW-1:0] tx_i;
  logic signed [SW-1:0] tx_q;
  logic                 tx_valid;
  logic                 busy;
  logic                 done;
  logic [15:0]          debugbus;

  match_filter_tx #(.SAMPLE_W(SW)) dut (
    .clk(clk), .reset(reset), .txstrobe(txstrobe), .start(start),
    .cdata(cdata), .cstate(cstate), .cwrite(cwrite),
    .tx_i(tx_i), .tx_q(tx_q), .tx_valid(tx_valid),
    .busy(busy), .done(done), .debugbus(debugbus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] words [16];
  int eqi[$];
  int eqq[$];
  int obi[$];
  int obq[$];
  int vcnt = 0;
  int dcnt = 0;
  bit armed = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected chip stream straight from the chip-numbering rules
  task automatic model();
    int n;
    int a;
    int r;
    int w;
    n = int'(words[1][7:0]);
    if (n > 224) n = 224;
    a = int'(words[0][14:0]);
    r = 0;
`ifdef MFTX_REPEAT_EN
    r = int'(words[1][11:8]);
`endif
    for (int p = 0; p <= r; p++) begin
      for (int k = n - 1; k >= 0; k--) begin
        w = 2 + 2 * (k / 32);
        eqi.push_back(words[w][k % 32] ? a : -a);
        eqq.push_back(words[w + 1][k % 32] ? a : -a);
      end
    end
  endtask

  always @(negedge clk) begin
    if (tx_valid) begin
      vcnt++;
      obi.push_back(int'(tx_i));
      obq.push_back(int'(tx_q));
      if (eqi.size() == 0) begin
        chk("extra_chip", 1, 0);
      end else begin
        chk("chip_i", tx_i, eqi.pop_front());
        chk("chip_q", tx_q, eqq.pop_front());
      end
    end
    if (done) begin
      dcnt++;
      chk("done_armed", armed, 1);
      chk("done_all_sent", eqi.size(), 0);
      armed = 1'b0;
    end
    if (!busy) begin
      chk("idle_tx_i_zero", tx_i, 0);
      chk("idle_tx_q_zero", tx_q, 0);
    end
    chk("dbg_flags", debugbus[15:13], {busy, done, tx_valid});
  end

  task automatic wr(input int a, input logic [31:0] d);
    cwrite = 1'b1;
    cstate = 4'(a);
    cdata  = d;
    words[a] = d;
    tick();
    cwrite = 1'b0;
  endtask

  task automatic run(input int sp, input int inj_at, input int rst_at,
                     input int budget);
    int v0;
    int d0;
    bit inj;
    bit ab;
    v0  = vcnt;
    d0  = dcnt;
    inj = 1'b0;
    ab  = 1'b0;
    model();
    armed = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < budget; c++) begin
      start  = 1'b0;
      cwrite = 1'b0;
      if (dcnt != d0) break;
      if (rst_at >= 0 && vcnt - v0 == rst_at) begin
        ab = 1'b1;
        break;
      end
      if (inj_at >= 0 && !inj && vcnt - v0 == inj_at) begin
        inj      = 1'b1;
        start    = 1'b1;
        cwrite   = 1'b1;
        cstate   = 4'd2;
        cdata    = 32'h0;
        txstrobe = 1'b0;
      end else begin
        txstrobe = (c % sp == sp - 1);
      end
      tick();
    end
    txstrobe = 1'b0;
    start    = 1'b0;
    cwrite   = 1'b0;
    if (ab) begin
      #1;
      reset = 1'b0;
      armed = 1'b0;
      #1;
      chk("abort_tx_i", tx_i, 0);
      chk("abort_tx_q", tx_q, 0);
      chk("abort_valid", tx_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      eqi.delete();
      eqq.delete();
      tick();
      tick();
      reset = 1'b1;
      tick();
    end else begin
      chk("done_seen", dcnt - d0, 1);
      tick();
    end
  endtask

  initial begin
    int v0;
    int o0;
    int d0;
    int lit_i[9];
    int lit_q[9];
    #2 reset = 1'b0;
    tick();
    chk("rst_tx_i", tx_i, 0);
    chk("rst_tx_q", tx_q, 0);
    chk("rst_valid", tx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dbg", debugbus, 0);
    reset = 1'b1;
    tick();

    // Four chips, 8-clock strobes
    wr(0, 32'd1000);
    wr(1, 32'd4);
    wr(2, 32'h5);
    wr(3, 32'hA);
    v0 = vcnt;
    o0 = obi.size();
    run(8, -1, -1, 200);
    chk("t1_count", vcnt - v0, 4);
    lit_i[0:3] = '{-1000, 1000, -1000, 1000};
    lit_q[0:3] = '{1000, -1000, 1000, -1000};
    for (int j = 0; j < 4; j++) begin
      if (o0 + j < obi.size()) begin
        chk("t1_lit_i", obi[o0 + j], lit_i[j]);
        chk("t1_lit_q", obq[o0 + j], lit_q[j]);
      end else begin
        chk("t1_missing", 0, 1);
      end
    end

    // 40 chips across a word boundary at the tightest strobe spacing
    wr(1, 32'd40);
    for (int w = 2; w < 6; w++) wr(w, 32'hFFFF_FFFF);
    v0 = vcnt;
    run(4, -1, -1, 400);
    chk("t2_count", vcnt - v0, 40);

    // Empty sequence: done two cycles after start
    wr(1, 32'd0);
    v0 = vcnt;
    d0 = dcnt;
    armed = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("n0_busy_c1", busy, 1);
    chk("n0_done_c1", done, 0);
    @(negedge clk);
    chk("n0_busy_c2", busy, 1);
    chk("n0_done_c2", done, 1);
    @(negedge clk);
    chk("n0_busy_c3", busy, 0);
    tick();
    chk("n0_valids", vcnt - v0, 0);
    chk("n0_dones", dcnt - d0, 1);

    // Restart and store write while busy are both ignored
    wr(0, 32'd12345);
    wr(1, 32'd20);
    wr(2, 32'h000A_5C3F);
    wr(3, 32'h0F0F_1234);
    v0 = vcnt;
    run(4, 10, -1, 300);
    chk("t4_count", vcnt - v0, 20);
    v0 = vcnt;
    run(4, -1, -1, 300);
    chk("t4_store_kept", vcnt - v0, 20);

    // Abort at chip 5, then a clean replay
    d0 = dcnt;
    run(5, -1, 5, 300);
    chk("t5_no_done", dcnt - d0, 0);
    v0 = vcnt;
    run(5, -1, -1, 300);
    chk("t5_replay", vcnt - v0, 20);

    // Clamp to 224 chips, full-scale amplitude, R field set
    wr(0, 32'h0000_7FFF);
    wr(1, 32'h0000_03FA);
    for (int w = 2; w < 16; w++) wr(w, $urandom);
    v0 = vcnt;
    run(4, -1, -1, 5000);
`ifdef MFTX_REPEAT_EN
    chk("t6_count", vcnt - v0, 896);
`else
    chk("t6_count", vcnt - v0, 224);
`endif

`ifdef MFTX_REPEAT_EN
    wr(0, 32'd77);
    wr(1, 32'h0000_0203);
    wr(2, 32'h5);
    wr(3, 32'h3);
    v0 = vcnt;
    o0 = obi.size();
    d0 = dcnt;
    run(6, -1, -1, 300);
    chk("t7_count", vcnt - v0, 9);
    chk("t7_dones", dcnt - d0, 1);
    for (int j = 0; j < 9; j++) begin
      lit_i[j] = (j % 3 == 1) ? -77 : 77;
      lit_q[j] = (j % 3 == 0) ? -77 : 77;
    end
    for (int j = 0; j < 9; j++) begin
      if (o0 + j < obi.size()) begin
        chk("t7_lit_i", obi[o0 + j], lit_i[j]);
        chk("t7_lit_q", obq[o0 + j], lit_q[j]);
      end else begin
        chk("t7_missing", 0, 1);
      end
    end
`endif

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
